// File: rtl/debug_uart_tx.sv
// Debug frame transmitter: snapshots seven CPU debug bytes and sends
// SYNC_BYTE, the seven bytes and their XOR checksum as 8N1 UART.
module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       send_i,
    input  logic [7:0] debug_port1_i,
    input  logic [7:0] debug_port2_i,
    input  logic [7:0] debug_port3_i,
    input  logic [7:0] debug_port4_i,
    input  logic [7:0] debug_port5_i,
    input  logic [7:0] debug_port6_i,
    input  logic [7:0] debug_port7_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    localparam int unsigned TIMER_W   = 16;
    localparam int unsigned NUM_PORTS = 7;
    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         LAST_BYTE = 4'd8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_q, state_n;
    logic [TIMER_W-1:0]   timer_q, timer_n;
    logic [2:0]           bit_q, bit_n;
    logic [3:0]           byte_q, byte_n;
    logic                 tx_n, busy_n, done_n;
    logic                 load_c, bit_last_c;
    logic [7:0]           port_c [NUM_PORTS];
    logic [7:0]           snap_q [NUM_PORTS];
    logic [7:0]           chk_c, byte_c;

    assign port_c[0] = debug_port1_i;
    assign port_c[1] = debug_port2_i;
    assign port_c[2] = debug_port3_i;
    assign port_c[3] = debug_port4_i;
    assign port_c[4] = debug_port5_i;
    assign port_c[5] = debug_port6_i;
    assign port_c[6] = debug_port7_i;

    assign bit_last_c = (timer_q == BIT_LAST);

    // Snapshot held for the whole frame; only reloaded on acceptance
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_PORTS; i++) snap_q[i] <= '0;
        end else if (load_c) begin
            for (int i = 0; i < NUM_PORTS; i++) snap_q[i] <= port_c[i];
        end
    end

    always_comb begin
        chk_c = '0;
        for (int i = 0; i < NUM_PORTS; i++) chk_c = chk_c ^ snap_q[i];
    end

    // State and counter register, plus registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_q        <= '0;
            byte_q       <= '0;
            tx_o         <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state_q      <= state_n;
            timer_q      <= timer_n;
            bit_q        <= bit_n;
            byte_q       <= byte_n;
            tx_o         <= tx_n;
            busy_o       <= busy_n;
            frame_done_o <= done_n;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_n = state_q;
        timer_n = timer_q;
        bit_n   = bit_q;
        byte_n  = byte_q;
        done_n  = 1'b0;
        load_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (send_i) begin
                    state_n = START;
                    timer_n = '0;
                    bit_n   = '0;
                    byte_n  = '0;
                    load_c  = 1'b1;
                end
            end
            START: begin
                if (bit_last_c) begin
                    state_n = DATA;
                    timer_n = '0;
                    bit_n   = '0;
                end else begin
                    timer_n = timer_q + TIMER_W'(1);
                end
            end
            DATA: begin
                if (bit_last_c) begin
                    timer_n = '0;
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_n = STOP;
                end else begin
                    timer_n = timer_q + TIMER_W'(1);
                end
            end
            STOP: begin
                if (bit_last_c) begin
                    timer_n = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_n = IDLE;
                        byte_n  = '0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = START;
                        byte_n  = byte_q + 4'd1;
                    end
                end else begin
                    timer_n = timer_q + TIMER_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Byte on the wire for the upcoming cycle: sync, snapshot, or checksum
    always_comb begin
        byte_c = SYNC_BYTE;
        if (byte_n == LAST_BYTE) begin
            byte_c = chk_c;
        end else if (byte_n != 4'd0) begin
            byte_c = snap_q[3'(byte_n - 4'd1)];
        end
    end

    always_comb begin
        tx_n   = 1'b1;
        busy_n = (state_n != IDLE);
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = byte_c[bit_n];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: cycle-count reference model plus a UART byte
// decoder feeding a scoreboard of expected frame bytes.
module tb_debug_uart_tx;

    localparam int         CPB       = 4;
    localparam int         FRAME_CYC = 90 * CPB;
    localparam logic [7:0] SYNC      = 8'hA5;

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b1;
    logic       send_i  = 1'b0;
    logic [7:0] dp [7];
    logic       tx_o, busy_o, frame_done_o;

    debug_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .send_i       (send_i),
        .debug_port1_i(dp[0]),
        .debug_port2_i(dp[1]),
        .debug_port3_i(dp[2]),
        .debug_port4_i(dp[3]),
        .debug_port5_i(dp[4]),
        .debug_port6_i(dp[5]),
        .debug_port7_i(dp[6]),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a frame is 90 bit times counted from acceptance
    logic [7:0] exp_q [$];
    logic [7:0] m_frame [9];
    int         m_rem      = 0;
    logic       m_done     = 1'b0;
    int         m_done_cnt = 0;
    logic [7:0] m_x;

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            m_rem  = 0;
            m_done = 1'b0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_rem != 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_done_cnt++;
                end
            end else if (send_i) begin
                m_x        = 8'h00;
                m_frame[0] = SYNC;
                for (int i = 0; i < 7; i++) begin
                    m_frame[i+1] = dp[i];
                    m_x          = m_x ^ dp[i];
                end
                m_frame[8] = m_x;
                for (int i = 0; i < 9; i++) exp_q.push_back(m_frame[i]);
                m_rem = FRAME_CYC;
            end
        end
    end

    function automatic logic exp_tx();
        int pos, bitn, b;
        if (m_rem == 0) return 1'b1;
        pos  = FRAME_CYC - m_rem;
        bitn = pos / CPB;
        b    = bitn % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_frame[bitn / 10][b - 1];
    endfunction

    // Per-cycle output comparison and event counters
    int busy_cyc     = 0;
    int dut_done_cnt = 0;

    always @(negedge clk_i) begin
        check("cycle_outputs", {29'd0, tx_o, busy_o, frame_done_o},
              {29'd0, exp_tx(), (m_rem != 0), m_done});
        if (busy_o) busy_cyc++;
        if (frame_done_o) dut_done_cnt++;
    end

    // UART monitor: decodes bytes off tx_o and checks them against the queue
    logic       dec_on  = 1'b0;
    int         dec_cnt = 0;
    logic       dec_s [10*CPB];
    logic       dec_stable;
    logic [7:0] dec_b, dec_e;

    always @(negedge clk_i) begin
        if (reset_i) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (tx_o == 1'b0) begin
                dec_on   = 1'b1;
                dec_s[0] = 1'b0;
                dec_cnt  = 1;
            end
        end else begin
            dec_s[dec_cnt] = tx_o;
            dec_cnt++;
            if (dec_cnt == 10*CPB) begin
                dec_on     = 1'b0;
                dec_stable = 1'b1;
                for (int k = 0; k < 10; k++)
                    for (int j = 1; j < CPB; j++)
                        if (dec_s[k*CPB+j] !== dec_s[k*CPB]) dec_stable = 1'b0;
                for (int i = 0; i < 8; i++) dec_b[i] = dec_s[(i+1)*CPB];
                check("bit_width", {31'd0, dec_stable}, 32'd1);
                check("framing", {30'd0, dec_s[0], dec_s[9*CPB]}, 32'd1);
                check("byte_pending", {31'd0, (exp_q.size() != 0)}, 32'd1);
                if (exp_q.size() != 0) begin
                    dec_e = exp_q.pop_front();
                    check("byte_value", {24'd0, dec_b}, {24'd0, dec_e});
                end
            end
        end
    end

    task automatic pulse();
        send_i = 1'b1;
        @(negedge clk_i);
        send_i = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    int b0, d0;

    initial begin
        for (int i = 0; i < 7; i++) dp[i] = 8'h00;
        wait_cyc(3);
        check("reset_tx", {31'd0, tx_o}, 32'd1);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_done", {31'd0, frame_done_o}, 32'd0);
        reset_i = 1'b0;
        wait_cyc(2);

        // Walking-one ports, single request
        for (int i = 0; i < 7; i++) dp[i] = 8'(1 << i);
        b0 = busy_cyc; d0 = dut_done_cnt;
        pulse();
        wait_cyc(370);
        check("t1_busy_cycles", 32'(busy_cyc - b0), 32'd360);
        check("t1_done_pulses", 32'(dut_done_cnt - d0), 32'd1);

        // Second request mid-frame is dropped
        d0 = dut_done_cnt;
        pulse();
        wait_cyc(99);
        pulse();
        wait_cyc(300);
        check("t2_done_pulses", 32'(dut_done_cnt - d0), 32'd1);

        // Port change during a frame must not reach the wire
        for (int i = 0; i < 7; i++) dp[i] = 8'($urandom);
        dp[0] = 8'h11;
        pulse();
        wait_cyc(50);
        dp[0] = 8'h22;
        wait_cyc(320);

        // All ones
        for (int i = 0; i < 7; i++) dp[i] = 8'hFF;
        d0 = dut_done_cnt;
        pulse();
        wait_cyc(370);
        check("t4_done_pulses", 32'(dut_done_cnt - d0), 32'd1);

        // Request held high: three back-to-back frames
        d0 = dut_done_cnt;
        send_i = 1'b1;
        wait_cyc(3*361 - 10);
        send_i = 1'b0;
        wait_cyc(30);
        check("t5_done_pulses", 32'(dut_done_cnt - d0), 32'd3);

        // Asynchronous reset in the middle of byte 3
        for (int i = 0; i < 7; i++) dp[i] = 8'($urandom);
        d0 = dut_done_cnt;
        pulse();
        wait_cyc(134);
        check("t6_busy_before", {31'd0, busy_o}, 32'd1);
        #2 reset_i = 1'b1;
        #1;
        check("t6_async_tx", {31'd0, tx_o}, 32'd1);
        check("t6_async_busy", {31'd0, busy_o}, 32'd0);
        wait_cyc(3);
        reset_i = 1'b0;
        check("t6_no_done", 32'(dut_done_cnt - d0), 32'd0);
        wait_cyc(2);
        for (int i = 0; i < 7; i++) dp[i] = 8'($urandom);
        pulse();
        wait_cyc(370);
        check("t6_done_after", 32'(dut_done_cnt - d0), 32'd1);

        // Random requests and port churn
        for (int c = 0; c < 2000; c++) begin
            send_i = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) dp[$urandom_range(0, 6)] = 8'($urandom);
            @(negedge clk_i);
        end
        send_i = 1'b0;

        for (int i = 0; i < 500 && (m_rem != 0 || busy_o); i++) @(negedge clk_i);
        wait_cyc(5);
        check("drain_idle", {31'd0, busy_o}, 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_total", 32'(dut_done_cnt), 32'(m_done_cnt));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
